// File: rtl/nem_ohmux_sel_ctrl.sv
// nem_ohmux_sel_ctrl: break-before-make one-hot select sequencer for a
// 4-input NEM relay inverting mux, with a saturating closure counter.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   req_valid/ready   select change request handshake
//   req_en, req_sel   close relay req_sel (1) or open all (0)
//   cfg_t_off/t_on    release / pull-in settle cycles (0 acts as 1)
//   S                 one-hot/zero relay selects
//   sel_valid         selected relay settled, ZN valid
//   cur_sel           index of closed relay (0 when none)
//   closures          saturating count of relay closures
//   clr_closures      synchronous clear of closures
module nem_ohmux_sel_ctrl #(
  parameter int T_W   = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_en,
  input  logic [1:0]       req_sel,
  input  logic [T_W-1:0]   cfg_t_off,
  input  logic [T_W-1:0]   cfg_t_on,
  output logic [3:0]       S,
  output logic             sel_valid,
  output logic [1:0]       cur_sel,
  output logic [CNT_W-1:0] closures,
  input  logic             clr_closures
);

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_BREAK,
    ST_MAKE,
    ST_HOLD
  } state_e;

  state_e           state_q;
  logic [3:0]       s_q;
  logic             sel_valid_q;
  logic             ready_q;
  logic [1:0]       cur_sel_q;
  logic [CNT_W-1:0] clos_q;
  logic [CNT_W-1:0] clos_d;
  logic [T_W-1:0]   cnt_q;
  logic [T_W-1:0]   ton_q;
  logic             en_q;
  logic [1:0]       sel_q;

  logic accept;
  logic make_go;
  logic last;

  function automatic logic [3:0] oh(
    input logic [1:0] i
  );
    return 4'b0001 << i;
  endfunction

  // Zero delay settings behave as a single cycle.
  function automatic logic [T_W-1:0] nz(
    input logic [T_W-1:0] t
  );
    return (t == '0) ? T_W'(1) : t;
  endfunction

  assign accept = req_valid & ready_q;
  assign last   = (cnt_q == T_W'(1));

  always_comb begin
    make_go = 1'b0;
    clos_d  = clos_q;
    if (state_q == ST_OPEN)
      make_go = accept & req_en;
    else if (state_q == ST_BREAK)
      make_go = last & en_q;
    if (clr_closures)
      clos_d = '0;
    else if (make_go && !(&clos_q))
      clos_d = clos_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OPEN;
      s_q         <= '0;
      sel_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      cur_sel_q   <= '0;
      clos_q      <= '0;
      cnt_q       <= '0;
      ton_q       <= '0;
      en_q        <= 1'b0;
      sel_q       <= '0;
    end else begin
      clos_q <= clos_d;
      unique case (state_q)
        ST_OPEN: begin
          if (accept && req_en) begin
            state_q   <= ST_MAKE;
            s_q       <= oh(req_sel);
            cur_sel_q <= req_sel;
            cnt_q     <= nz(cfg_t_on);
            ready_q   <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Same-index requests are absorbed.
          if (accept &&
              !(req_en && req_sel == cur_sel_q)) begin
            state_q     <= ST_BREAK;
            s_q         <= '0;
            sel_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            en_q        <= req_en;
            sel_q       <= req_sel;
            ton_q       <= nz(cfg_t_on);
            cnt_q       <= nz(cfg_t_off);
          end
        end
        ST_BREAK: begin
          if (last) begin
            if (en_q) begin
              state_q   <= ST_MAKE;
              s_q       <= oh(sel_q);
              cur_sel_q <= sel_q;
              cnt_q     <= ton_q;
            end else begin
              state_q   <= ST_OPEN;
              cur_sel_q <= '0;
              ready_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - T_W'(1);
          end
        end
        ST_MAKE: begin
          if (last) begin
            state_q     <= ST_HOLD;
            sel_valid_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - T_W'(1);
          end
        end
      endcase
    end
  end

  assign S         = s_q;
  assign sel_valid = sel_valid_q;
  assign req_ready = ready_q;
  assign cur_sel   = cur_sel_q;
  assign closures  = clos_q;

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// tb_nem_ohmux_sel_ctrl: directed bench for the relay select sequencer.
// DUT built with CNT_W=4 so counter saturation is reachable.
module tb_nem_ohmux_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_en;
  logic [1:0] req_sel;
  logic [7:0] cfg_t_off;
  logic [7:0] cfg_t_on;
  logic [3:0] S;
  logic       sel_valid;
  logic [1:0] cur_sel;
  logic [3:0] closures;
  logic       clr_closures;

  int n_run;
  int n_fail;
  int exp_clos;

  nem_ohmux_sel_ctrl #(
    .T_W  (8),
    .CNT_W(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_en      (req_en),
    .req_sel     (req_sel),
    .cfg_t_off   (cfg_t_off),
    .cfg_t_on    (cfg_t_on),
    .S           (S),
    .sel_valid   (sel_valid),
    .cur_sel     (cur_sel),
    .closures    (closures),
    .clr_closures(clr_closures)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot0", 32'($countones(S) <= 1), 1);
  endtask

  // Request a close of relay sel and follow it to HOLD.
  task automatic run_switch(
    input logic [1:0] sel,
    input logic [7:0] toff,
    input logic [7:0] ton,
    input bit         from_open
  );
    int         te;
    int         tn;
    logic [3:0] ohv;
    te  = (toff == 0) ? 1 : int'(toff);
    tn  = (ton == 0) ? 1 : int'(ton);
    if (from_open) te = 0;
    ohv = 4'b0001 << sel;
    chk("ready_pre", req_ready, 1);
    req_valid = 1'b1;
    req_en    = 1'b1;
    req_sel   = sel;
    cfg_t_off = toff;
    cfg_t_on  = ton;
    tick();
    req_valid = 1'b0;
    cfg_t_off = 8'd200;
    cfg_t_on  = 8'd200;
    if (exp_clos < 15) exp_clos++;
    for (int e = 0; e <= te + tn; e++) begin
      if (e > 0) tick();
      chk("sw_S", S, (e >= te) ? ohv : 4'b0);
      chk("sw_valid", sel_valid, e >= te + tn);
      chk("sw_ready", req_ready, e >= te + tn);
    end
    chk("sw_cur", cur_sel, sel);
    chk("sw_clos", closures, exp_clos);
  endtask

  initial begin
    n_run        = 0;
    n_fail       = 0;
    exp_clos     = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_en       = 1'b0;
    req_sel      = 2'd0;
    cfg_t_off    = 8'd0;
    cfg_t_on     = 8'd0;
    clr_closures = 1'b0;
    #3;
    chk("rst_S", S, 0);
    chk("rst_valid", sel_valid, 0);
    chk("rst_cur", cur_sel, 0);
    chk("rst_clos", closures, 0);
    chk("rst_ready", req_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // First select from OPEN, Ton=5.
    run_switch(2'd2, 8'd0, 8'd5, 1'b1);
    // Break-before-make switch 2 -> 1.
    run_switch(2'd1, 8'd3, 8'd4, 1'b0);
    // Zero delays.
    run_switch(2'd0, 8'd1, 8'd1, 1'b0);
    run_switch(2'd3, 8'd0, 8'd0, 1'b0);

    // Back-to-back same-index requests.
    req_valid = 1'b1;
    req_en    = 1'b1;
    req_sel   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("same_ready", req_ready, 1);
      chk("same_S", S, 4'b1000);
      chk("same_valid", sel_valid, 1);
      chk("same_clos", closures, exp_clos);
    end
    req_valid = 1'b0;

    // Open-all from HOLD, Toff=2.
    req_valid = 1'b1;
    req_en    = 1'b0;
    cfg_t_off = 8'd2;
    tick();
    req_valid = 1'b0;
    chk("oa0_S", S, 0);
    chk("oa0_valid", sel_valid, 0);
    chk("oa0_ready", req_ready, 0);
    tick();
    chk("oa1_ready", req_ready, 0);
    tick();
    chk("oa2_ready", req_ready, 1);
    chk("oa2_cur", cur_sel, 0);
    chk("oa2_S", S, 0);
    // Open-all in OPEN is a no-op.
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("noop_ready", req_ready, 1);
    chk("noop_S", S, 0);
    chk("noop_clos", closures, exp_clos);

    // Reset in the middle of MAKE.
    req_valid = 1'b1;
    req_en    = 1'b1;
    req_sel   = 2'd1;
    cfg_t_on  = 8'd10;
    tick();
    req_valid = 1'b0;
    chk("mk_S", S, 4'b0010);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mrst_S", S, 0);
    chk("mrst_valid", sel_valid, 0);
    chk("mrst_cur", cur_sel, 0);
    chk("mrst_clos", closures, 0);
    chk("mrst_ready", req_ready, 1);
    exp_clos = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Maximum delays.
    run_switch(2'd2, 8'd0, 8'd255, 1'b1);
    run_switch(2'd1, 8'd255, 8'd1, 1'b0);

    // Saturation after many closures.
    for (int i = 0; i < 17; i++)
      run_switch((i % 2 == 1) ? 2'd1 : 2'd3,
                 8'd1, 8'd1, 1'b0);
    chk("sat", closures, 15);

    // Clear coinciding with MAKE entry.
    req_valid = 1'b1;
    req_en    = 1'b1;
    req_sel   = 2'd0;
    cfg_t_off = 8'd1;
    cfg_t_on  = 8'd1;
    tick();
    req_valid    = 1'b0;
    clr_closures = 1'b1;
    tick();
    clr_closures = 1'b0;
    chk("clr_clos", closures, 0);
    chk("clr_S", S, 4'b0001);
    tick();
    chk("clr_valid", sel_valid, 1);
    chk("clr_clos2", closures, 0);
    exp_clos = 0;
    run_switch(2'd2, 8'd1, 8'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
